ad9945_spi_slave: RTL

- Synthesizable model of the AD9945 AFE 3-wire serial port: the receiving end of the SL/SCK/SDATA configuration link.
- Oversamples the link on sys_clk, decodes LSB-first address+data frames and updates the four AFE configuration registers (Oper, Ctrl, Clamp, VGA_Gain).
- Used in CCD/AFE simulation benches and as an on-chip loopback checker alongside the AFE configuration writer.

---
 rtl/ad9945_spi_slave.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/ad9945_spi_slave.sv
// AD9945 AFE 3-wire serial port receiver: oversampled SL/SCK/SDATA, LSB-first addr+data frames.
// Optional frame-length checking is enabled with `define AD9945_SLV_LEN_CHK_EN.
module ad9945_spi_slave #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [6:0]  DEF_OPER    = 7'h00,
    parameter logic [6:0]  DEF_CTRL    = 7'h00,
    parameter logic [7:0]  DEF_CLAMP   = 8'h80,
    parameter logic [9:0]  DEF_VGA     = 10'h000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       SL,
    input  logic       SCK,
    input  logic       SDATA,
    output logic [6:0] Oper,
    output logic [6:0] Ctrl,
    output logic [7:0] Clamp,
    output logic [9:0] VGA_Gain,
    output logic       wr_pulse,
    output logic [2:0] wr_addr,
    output logic       addr_err,
    output logic       len_err,
    output logic       busy
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned SR_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(16);
    localparam logic [CNT_W-1:0] CNT_HDR = CNT_W'(3);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    logic [SYNC_STAGES-1:0] sl_sync_q, sck_sync_q, sda_sync_q;
    logic                   sl_dly_q, sck_dly_q;
    logic [SYNC_STAGES:0]   vld_q;
    logic                   armed_q;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [SR_W-1:0]  shift_q, shift_d;
    logic [6:0]       oper_q, oper_d;
    logic [6:0]       ctrl_q, ctrl_d;
    logic [7:0]       clamp_q, clamp_d;
    logic [9:0]       vga_q, vga_d;
    logic [2:0]       wr_addr_q, wr_addr_d;
    logic             wr_pulse_q, wr_pulse_d;
    logic             addr_err_q, addr_err_d;
    logic             len_err_q, len_err_d;
    logic             busy_q, busy_d;

    logic       sl_s, sck_s, sda_s;
    logic       sl_fall, sl_rise, sck_rise;
    logic [2:0] addr_c;
    logic [9:0] data_c;
    logic       len_ok_c;
    logic       unused_shift_c;

    // Input synchronizers plus edge-detect delay flops
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sl_sync_q  <= '1;
            sck_sync_q <= '0;
            sda_sync_q <= '0;
            sl_dly_q   <= 1'b1;
            sck_dly_q  <= 1'b0;
            vld_q      <= '0;
            armed_q    <= 1'b0;
        end else begin
            sl_sync_q  <= {sl_sync_q[SYNC_STAGES-2:0], SL};
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], SCK};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDATA};
            sl_dly_q   <= sl_s;
            sck_dly_q  <= sck_s;
            vld_q      <= {vld_q[SYNC_STAGES-1:0], 1'b1};
            armed_q    <= armed_q | (vld_q[SYNC_STAGES] & sl_dly_q);
        end
    end

    assign sl_s  = sl_sync_q[SYNC_STAGES-1];
    assign sck_s = sck_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    // A frame may only start once a genuine high level on SL has been seen since reset,
    // so an SL held low across reset release does not look like a falling edge.
    assign sl_fall  = armed_q & sl_dly_q & ~sl_s;
    assign sl_rise  = ~sl_dly_q & sl_s;
    assign sck_rise = ~sck_dly_q & sck_s;

    assign addr_c         = shift_q[2:0];
    assign data_c         = shift_q[12:3];
    assign unused_shift_c = ^shift_q[15:13];

`ifdef AD9945_SLV_LEN_CHK_EN
    always_comb begin
        len_ok_c = 1'b0;
        case (addr_c[1:0])
            2'd0, 2'd1: len_ok_c = (bit_cnt_q == CNT_W'(10));
            2'd2:       len_ok_c = (bit_cnt_q == CNT_W'(11));
            default:    len_ok_c = (bit_cnt_q == CNT_W'(13));
        endcase
    end
`else
    assign len_ok_c = 1'b1;
`endif

    // State and output registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            oper_q     <= DEF_OPER;
            ctrl_q     <= DEF_CTRL;
            clamp_q    <= DEF_CLAMP;
            vga_q      <= DEF_VGA;
            wr_addr_q  <= '0;
            wr_pulse_q <= 1'b0;
            addr_err_q <= 1'b0;
            len_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            oper_q     <= oper_d;
            ctrl_q     <= ctrl_d;
            clamp_q    <= clamp_d;
            vga_q      <= vga_d;
            wr_addr_q  <= wr_addr_d;
            wr_pulse_q <= wr_pulse_d;
            addr_err_q <= addr_err_d;
            len_err_q  <= len_err_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state and register-update logic
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        oper_d     = oper_q;
        ctrl_d     = ctrl_q;
        clamp_d    = clamp_q;
        vga_d      = vga_q;
        wr_addr_d  = wr_addr_q;
        wr_pulse_d = 1'b0;
        addr_err_d = 1'b0;
        len_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sl_fall) begin
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A coincident SCK rise is captured before the frame closes
                if (sck_rise && (bit_cnt_q != CNT_MAX)) begin
                    shift_d[bit_cnt_q[3:0]] = sda_s;
                    bit_cnt_d               = bit_cnt_q + CNT_W'(1);
                end
                if (sl_rise) begin
                    state_d = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
                if (bit_cnt_q >= CNT_HDR) begin
                    wr_addr_d = addr_c;
                    if (addr_c[2]) begin
                        addr_err_d = 1'b1;
                    end else if (!len_ok_c) begin
                        len_err_d = 1'b1;
                    end else begin
                        wr_pulse_d = 1'b1;
                        case (addr_c[1:0])
                            2'd0:    oper_d  = data_c[6:0];
                            2'd1:    ctrl_d  = data_c[6:0];
                            2'd2:    clamp_d = data_c[7:0];
                            default: vga_d   = data_c;
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign Oper     = oper_q;
    assign Ctrl     = ctrl_q;
    assign Clamp    = clamp_q;
    assign VGA_Gain = vga_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign addr_err = addr_err_q;
    assign len_err  = len_err_q;
    assign busy     = busy_q;

endmodule
